// File: rtl/tap_recorder.sv
// tap_recorder: times cass_write falling edges in ce_1m ticks, encodes each
// period as TAP v1 bytes, queues them in a small FIFO and writes them to tape
// RAM over a req/ack port. On stop it drains, then writes the 20-byte header.
module tap_recorder #(
  parameter int ADDR_W  = 25,
  parameter int FIFO_AW = 4,
  parameter int HDR_LEN = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_1m,
  input  logic              rec_arm,
  input  logic              rec_stop,
  input  logic              cass_write,
  input  logic              cass_motor_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dout,
  input  logic              mem_ack,
  output logic [31:0]       tape_len,
  output logic              rec_active,
  output logic              rec_done,
  output logic              overflow
);
  localparam longint      MAX_BYTES = longint'(1) << ADDR_W;
  localparam logic [31:0] MAX_DATA  = 32'(MAX_BYTES - longint'(HDR_LEN));
  localparam int          DEPTH     = 1 << FIFO_AW;

  typedef enum logic [2:0] {S_IDLE, S_REC, S_DRAIN, S_HDR, S_DONE} state_t;
  state_t state, state_nx;

  logic               prev_cw, first_edge;
  logic [23:0]        cyc, ev_len;
  logic [31:0]        enc_sr;
  logic [2:0]         enc_cnt;
  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW:0]   wr_ptr, rd_ptr;
  logic [4:0]         hdr_idx;
  logic arm_go, tick, fall, sat, ev, len_full, enc_busy;
  logic fifo_empty, fifo_full, push, pop, drain_done, ack_hit;

  // Fixed TAP v1 header; the last four bytes carry the data length.
  function automatic logic [7:0] hdr_byte(input logic [4:0] idx, input logic [31:0] len);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      5'd0:  b = 8'h43;  5'd1:  b = 8'h36;  5'd2:  b = 8'h34;  5'd3:  b = 8'h2D;
      5'd4:  b = 8'h54;  5'd5:  b = 8'h41;  5'd6:  b = 8'h50;  5'd7:  b = 8'h45;
      5'd8:  b = 8'h2D;  5'd9:  b = 8'h52;  5'd10: b = 8'h41;  5'd11: b = 8'h57;
      5'd12: b = 8'h01;
      5'd16: b = len[7:0];   5'd17: b = len[15:8];
      5'd18: b = len[23:16]; 5'd19: b = len[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign arm_go     = rec_arm && (state == S_IDLE || state == S_DONE);
  assign tick       = ce_1m && !cass_motor_n && (state == S_REC);
  assign fall       = tick && prev_cw && !cass_write;
  assign sat        = tick && !fall && (cyc == 24'hFFFFFF);
  // Period includes the edge tick itself; clamp so a saturated counter never wraps.
  assign ev_len     = (fall && cyc != 24'hFFFFFF) ? cyc + 24'd1 : 24'hFFFFFF;
  assign len_full   = tape_len >= MAX_DATA;
  assign ev         = ((fall && !first_edge) || sat) && !len_full;
  assign enc_busy   = enc_cnt != 3'd0;
  assign fifo_empty = wr_ptr == rd_ptr;
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign push       = enc_busy && !fifo_full && !len_full;
  assign pop        = (state == S_REC || state == S_DRAIN) && !mem_req && !fifo_empty && !len_full;
  // Once the tape is full, leftover FIFO/encoder bytes are abandoned.
  assign drain_done = !mem_req && (len_full || (!enc_busy && fifo_empty));
  assign ack_hit    = mem_req && mem_ack;
  assign rec_active = (state == S_REC) || (state == S_DRAIN);
  assign rec_done   = state == S_DONE;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (arm_go) state_nx = S_REC;
      S_REC:   if (rec_stop || len_full) state_nx = S_DRAIN;
      S_DRAIN: if (drain_done) state_nx = S_HDR;
      S_HDR:   if (ack_hit && hdr_idx == 5'(HDR_LEN - 1)) state_nx = S_DONE;
      S_DONE:  if (arm_go) state_nx = S_REC;
      default: state_nx = S_IDLE;
    endcase
  end

  // Period timer and encoder stage (up to 4 bytes, drained one per clk).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_cw <= 1'b0; first_edge <= 1'b0; cyc <= '0;
      enc_sr <= '0; enc_cnt <= '0; overflow <= 1'b0;
    end else begin
      if (ce_1m) prev_cw <= cass_write;
      if (arm_go) begin
        first_edge <= 1'b1; cyc <= '0; enc_cnt <= '0; overflow <= 1'b0;
      end else begin
        if (tick) begin
          if (fall) begin cyc <= '0; first_edge <= 1'b0; end
          else if (sat) cyc <= '0;
          else cyc <= cyc + 24'd1;
        end
        if (ev && !enc_busy) begin
          if (ev_len < 24'd8)         begin enc_sr <= 32'h01;               enc_cnt <= 3'd1; end
          else if (ev_len < 24'd2048) begin enc_sr <= {24'h0, ev_len[10:3]}; enc_cnt <= 3'd1; end
          else                        begin enc_sr <= {ev_len, 8'h00};      enc_cnt <= 3'd4; end
        end else if (push) begin
          enc_sr  <= enc_sr >> 8;
          enc_cnt <= enc_cnt - 3'd1;
        end
        if ((ev && enc_busy) || len_full) overflow <= 1'b1;
      end
    end
  end

  // FIFO pointers; arm flushes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0; rd_ptr <= '0;
    end else if (arm_go) begin
      wr_ptr <= '0; rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= enc_sr[7:0];
  end

  // Memory writer: one byte per handshake, req low for a clk after each ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req <= 1'b0; mem_addr <= '0; mem_dout <= '0; tape_len <= '0; hdr_idx <= '0;
    end else if (arm_go) begin
      mem_req <= 1'b0; tape_len <= '0; hdr_idx <= '0;
    end else if (mem_req) begin
      if (mem_ack) begin
        mem_req <= 1'b0;
        if (state == S_HDR) hdr_idx <= hdr_idx + 5'd1;
        else                tape_len <= tape_len + 32'd1;
      end
    end else if (pop) begin
      mem_req  <= 1'b1;
      mem_dout <= fifo_mem[rd_ptr[FIFO_AW-1:0]];
      mem_addr <= ADDR_W'(tape_len + 32'(HDR_LEN));
    end else if (state == S_HDR && hdr_idx < 5'(HDR_LEN)) begin
      mem_req  <= 1'b1;
      mem_dout <= hdr_byte(hdr_idx, tape_len);
      mem_addr <= ADDR_W'(hdr_idx);
    end
  end
endmodule

// File: tb/tb_tap_recorder.sv
// tb_tap_recorder: drives tick-accurate cass_write pulses, models the TAP
// byte stream from the encoding rules, emulates tape RAM with random acks and
// compares the recorded image (data + header) after each recording.
module tb_tap_recorder;
  logic        clk = 1'b0, reset_n = 1'b0, ce_1m = 1'b0, rec_arm = 1'b0, rec_stop = 1'b0;
  logic        cass_write = 1'b0, cass_motor_n = 1'b0, mem_ack = 1'b0;
  logic        mem_req, rec_active, rec_done, overflow;
  logic [24:0] mem_addr;
  logic [7:0]  mem_dout;
  logic [31:0] tape_len;

  tap_recorder dut (
    .clk(clk), .reset_n(reset_n), .ce_1m(ce_1m), .rec_arm(rec_arm), .rec_stop(rec_stop),
    .cass_write(cass_write), .cass_motor_n(cass_motor_n), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_ack(mem_ack), .tape_len(tape_len),
    .rec_active(rec_active), .rec_done(rec_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  logic [7:0] exp_q[$];
  bit m_rec = 0, m_first = 0, m_prev = 0, m_drop = 0, m_ovf = 0;
  int m_cnt = 0;
  logic [7:0] mem_model [1024];
  bit         mem_wr    [1024];
  bit         hold_ack = 0;
  logic [7:0] hdr_c [12] = '{8'h43, 8'h36, 8'h34, 8'h2D, 8'h54, 8'h41,
                            8'h50, 8'h45, 8'h2D, 8'h52, 8'h41, 8'h57};

  function automatic void encode(input int len);
    if (len < 8)         exp_q.push_back(8'h01);
    else if (len < 2048) exp_q.push_back(8'(len / 8));
    else begin
      exp_q.push_back(8'h00);
      exp_q.push_back(8'(len % 256));
      exp_q.push_back(8'((len / 256) % 256));
      exp_q.push_back(8'(len / 65536));
    end
  endfunction

  // period = motor-on ticks since the previous falling edge, edge tick included
  function automatic void model_tick(input bit cw, input bit mot_n);
    if (m_rec && !mot_n) begin
      m_cnt++;
      if (m_prev && !cw) begin
        if (m_first)     m_first = 0;
        else if (m_drop) begin m_drop = 0; m_ovf = 1; end
        else             encode(m_cnt);
        m_cnt = 0;
      end
    end
    m_prev = cw;
  endfunction

  // tape RAM: random ack latency, unless held off
  initial forever begin
    @(negedge clk);
    if (mem_ack) mem_ack = 1'b0;
    else if (reset_n && mem_req && !hold_ack && $urandom_range(0, 2) == 0) begin
      mem_ack = 1'b1;
      mem_model[mem_addr[9:0]] = mem_dout;
      mem_wr[mem_addr[9:0]]    = 1'b1;
    end
  end

  task automatic tick(input bit cw, input bit mot_n, input bit stop);
    @(negedge clk);
    ce_1m = 1'b1; cass_write = cw; cass_motor_n = mot_n; rec_stop = stop;
    model_tick(cw, mot_n);
    if (stop) m_rec = 0;
    @(negedge clk);
    ce_1m = 1'b0; rec_stop = 1'b0;
    if ($urandom_range(0, 3) == 0) @(negedge clk);
  endtask

  task automatic gap(input int n, input bit stop_last);
    for (int i = 0; i < n - 1; i++) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, stop_last);
  endtask

  task automatic wait_len(input int n);
    int k = 0;
    while (tape_len != 32'(n) && k < 3000) begin @(negedge clk); k++; end
    chk("len_wait", tape_len, 32'(n));
  endtask

  // gap whose final edge is timed to the first mem_req (queue idle beforehand)
  task automatic lat_gap(input int n);
    int k;
    for (int i = 0; i < n - 1; i++) tick(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    ce_1m = 1'b1; cass_write = 1'b0;
    model_tick(1'b0, 1'b0);
    @(negedge clk);
    ce_1m = 1'b0;
    k = 1;
    while (!mem_req && k < 10) begin @(negedge clk); k++; end
    chk("edge_to_req_le3", 32'(mem_req && k <= 3), 32'd1);
  endtask

  task automatic arm();
    @(negedge clk); rec_arm = 1'b1;
    @(negedge clk); rec_arm = 1'b0;
    exp_q.delete();
    m_rec = 1; m_first = 1; m_cnt = 0; m_drop = 0; m_ovf = 0;
    for (int i = 0; i < 1024; i++) mem_wr[i] = 1'b0;
    chk("arm_len", tape_len, 32'd0);
    chk("arm_ovf", 32'(overflow), 32'd0);
    chk("arm_active", 32'(rec_active), 32'd1);
  endtask

  task automatic record_end(input bit do_stop);
    int k = 0;
    logic [31:0] len;
    logic [7:0]  eb;
    if (do_stop) begin
      @(negedge clk); rec_stop = 1'b1; m_rec = 0;
      @(negedge clk); rec_stop = 1'b0;
    end
    while (!rec_done && k < 5000) begin @(negedge clk); k++; end
    chk("rec_done", 32'(rec_done), 32'd1);
    chk("done_inactive", 32'(rec_active), 32'd0);
    len = 32'(exp_q.size());
    chk("tape_len", tape_len, len);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    foreach (exp_q[i])
      chk($sformatf("data[%0d]", i), {23'd0, mem_wr[20 + i], mem_model[20 + i]}, {23'd0, 1'b1, exp_q[i]});
    for (int i = 0; i < 20; i++) begin
      if (i < 12)      eb = hdr_c[i];
      else if (i == 12) eb = 8'h01;
      else if (i < 16) eb = 8'h00;
      else             eb = 8'(len >> (8 * (i - 16)));
      chk($sformatf("hdr[%0d]", i), {23'd0, mem_wr[i], mem_model[i]}, {23'd0, 1'b1, eb});
    end
  endtask

  initial begin
    int k;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_dout", 32'(mem_dout), 32'd0);
    chk("rst_len", tape_len, 32'd0);
    chk("rst_flags", {29'd0, rec_active, rec_done, overflow}, 32'd0);
    reset_n = 1'b1;
    // IDLE ignores stop and edges
    @(negedge clk); rec_stop = 1'b1; @(negedge clk); rec_stop = 1'b0;
    tick(1'b1, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0); tick(1'b1, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("idle_active", 32'(rec_active), 32'd0);
    chk("idle_req", 32'(mem_req), 32'd0);

    // 400-tick pulses, 10 data bytes, header with length 10
    arm();
    gap(10, 1'b0);
    for (int i = 0; i < 8; i++) gap(400, 1'b0);
    wait_len(8);
    lat_gap(400);
    gap(400, 1'b0);
    wait_len(10);
    record_end(1'b1);

    // long form
    arm();
    gap(10, 1'b0);
    gap(3000, 1'b0);
    wait_len(4);
    record_end(1'b1);

    // short/medium/long boundaries; stop on the same tick as the last edge
    arm();
    gap(10, 1'b0);
    gap(5, 1'b0);
    gap(2047, 1'b0);
    gap(2048, 1'b1);
    record_end(1'b0);

    // motor-off ticks are not counted
    arm();
    gap(10, 1'b0);
    for (int i = 0; i < 200; i++)  tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 199; i++)  tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    wait_len(1);
    record_end(1'b1);

    // randomized periods
    arm();
    gap(10, 1'b0);
    for (int i = 0; i < 6; i++) gap(int'($urandom_range(8, 3000)), 1'b0);
    record_end(1'b1);

    // ack stalled through a long-pulse burst: nothing lost
    arm();
    gap(10, 1'b0);
    hold_ack = 1;
    for (int i = 0; i < 4; i++) gap(2100, 1'b0);
    repeat (40) @(negedge clk);
    chk("stall_no_ovf", 32'(overflow), 32'd0);
    chk("stall_req_held", 32'(mem_req), 32'd1);
    hold_ack = 0;
    wait_len(16);
    record_end(1'b1);

    // encoder stage still busy when the next edge arrives: event dropped
    arm();
    gap(10, 1'b0);
    hold_ack = 1;
    for (int i = 0; i < 5; i++) gap(2100, 1'b0);
    m_drop = 1;
    gap(400, 1'b0);
    chk("drop_ovf", 32'(overflow), 32'd1);
    hold_ack = 0;
    wait_len(20);
    gap(400, 1'b0);
    wait_len(21);
    record_end(1'b1);

    // asynchronous reset with a request in flight
    arm();
    gap(10, 1'b0);
    hold_ack = 1;
    gap(400, 1'b0);
    k = 0;
    while (!mem_req && k < 20) begin @(negedge clk); k++; end
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(mem_req), 32'd0);
    chk("rst_mid_active", 32'(rec_active), 32'd0);
    chk("rst_mid_len", tape_len, 32'd0);
    hold_ack = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {30'd0, rec_active, rec_done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
